// File: rtl/mem_bus_pkg.sv
// Shared encodings and bus widths for the inst/data memory-port arbiter.
// Imported by the owner FIFO and the arbiter top level.
package mem_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic              req;
        logic              wr;
        logic [1:0]        size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/mem_bus_arbiter_owner_fifo.sv
// In-order record of which channel owns each accepted, unreturned request.
// One bit per entry; push ignored when full, pop ignored when empty.
module owner_fifo
    import mem_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == CNT_FULL);
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign head      = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointers are log2(DEPTH) wide so they wrap without explicit compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-to-one sram-like arbiter: data over inst, stalled grants pinned,
// responses routed back to their owner through an in-order owner FIFO.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [STRB_W-1:0] inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              proto_err
);

    sram_req_t w_inst;
    sram_req_t w_data;
    sram_req_t w_sel;

    logic r_lock_valid;
    logic r_lock_owner;
    logic r_proto_err;

    logic w_grant;
    logic w_mem_req;
    logic w_accept;
    logic w_ret;
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_head;

    assign w_inst = '{
        req:   inst_req,
        wr:    inst_wr,
        size:  inst_size,
        wstrb: inst_wstrb,
        addr:  inst_addr,
        wdata: inst_wdata
    };

    assign w_data = '{
        req:   data_req,
        wr:    data_wr,
        size:  data_size,
        wstrb: data_wstrb,
        addr:  data_addr,
        wdata: data_wdata
    };

    // A stalled grant is held so the bus request never changes before accept.
    always_comb begin
        w_grant = OWNER_INST;
        if (r_lock_valid) begin
            w_grant = r_lock_owner;
        end else if (data_req) begin
            w_grant = OWNER_DATA;
        end
    end

    assign w_sel     = (w_grant == OWNER_DATA) ? w_data : w_inst;
    assign w_mem_req = w_sel.req & ~w_fifo_full & ~reset;
    assign w_accept  = w_mem_req & mem_addr_ok;
    assign w_ret     = mem_data_ok & ~w_fifo_empty & ~reset;

    assign mem_req   = w_mem_req;
    assign mem_wr    = w_sel.wr;
    assign mem_size  = w_sel.size;
    assign mem_wstrb = w_sel.wstrb;
    assign mem_addr  = w_sel.addr;
    assign mem_wdata = w_sel.wdata;

    assign inst_addr_ok = w_accept & (w_grant == OWNER_INST);
    assign data_addr_ok = w_accept & (w_grant == OWNER_DATA);

    assign inst_data_ok = w_ret & (w_head == OWNER_INST);
    assign data_data_ok = w_ret & (w_head == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign proto_err = r_proto_err & ~reset;

    owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_accept),
        .din   (w_grant),
        .pop   (w_ret),
        .head  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_valid <= 1'b0;
            r_lock_owner <= OWNER_INST;
        end else if (w_accept) begin
            r_lock_valid <= 1'b0;
        end else if (w_mem_req) begin
            r_lock_valid <= 1'b1;
            r_lock_owner <= w_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_proto_err <= 1'b0;
        end else if (mem_data_ok & w_fifo_empty) begin
            r_proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter against a queue-based
// model of grant priority, pinning, outstanding limit and in-order returns.
module tb_mem_bus_arbiter;

    localparam int OUT = 4;

    typedef struct {
        bit          own;
        bit          wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        bit          own;
        logic [31:0] rdata;
    } ret_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = '0;
    logic [3:0]  inst_wstrb = '0;
    logic [31:0] inst_addr = '0, inst_wdata = '0;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = '0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        proto_err;

    mem_bus_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    acc_t acc_q[$];
    ret_t ret_q[$];
    bit   exp_mreq = 1'b0;
    bit   exp_perr = 1'b0;
    bit   chk_en = 1'b0;

    // Reference model state: outstanding owners in order, pinned grant.
    bit   m_q[$];
    bit   m_lockv = 1'b0;
    bit   m_lockown = 1'b0;
    bit   m_perr = 1'b0;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    acc_t me;
    ret_t mr;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", 32'(mem_req), 32'(exp_mreq));
            chk("proto_err", 32'(proto_err), 32'(exp_perr));
            if (inst_addr_ok || data_addr_ok || acc_q.size() > 0) begin
                if (acc_q.size() == 0) begin
                    chk("spurious_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
                end else begin
                    me = acc_q.pop_front();
                    chk("addr_ok_owner", {inst_addr_ok, data_addr_ok},
                        me.own ? 32'd1 : 32'd2);
                    chk("mem_addr", mem_addr, me.addr);
                    chk("mem_wdata", mem_wdata, me.wdata);
                    chk("mem_ctrl", {mem_wr, mem_size, mem_wstrb},
                        {me.wr, me.size, me.wstrb});
                end
            end
            if (inst_data_ok || data_data_ok || ret_q.size() > 0) begin
                if (ret_q.size() == 0) begin
                    chk("spurious_data_ok", {inst_data_ok, data_data_ok}, 0);
                end else begin
                    mr = ret_q.pop_front();
                    chk("data_ok_owner", {inst_data_ok, data_data_ok},
                        mr.own ? 32'd1 : 32'd2);
                    chk("rdata", mr.own ? data_rdata : inst_rdata, mr.rdata);
                end
            end
        end
    end

    task automatic new_inst();
        inst_req   = 1'b1;
        inst_wr    = 1'($urandom_range(0, 1));
        inst_size  = 2'($urandom_range(0, 2));
        inst_wstrb = 4'($urandom);
        inst_addr  = $urandom;
        inst_wdata = $urandom;
    endtask

    task automatic new_data();
        data_req   = 1'b1;
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
    endtask

    // One clock: predict from the model, queue expectations, advance.
    task automatic step();
        bit   g, greq, mreq, acc, ret;
        int   pre;
        acc_t a;
        if (reset) begin
            exp_mreq = 1'b0;
            exp_perr = 1'b0;
            @(posedge clk);
            #1;
            m_q.delete();
            m_lockv = 1'b0;
            m_perr = 1'b0;
            inst_req = 1'b0;
            data_req = 1'b0;
            return;
        end
        pre  = m_q.size();
        g    = m_lockv ? m_lockown : data_req;
        greq = g ? data_req : inst_req;
        mreq = greq && (pre < OUT);
        acc  = mreq && mem_addr_ok;
        ret  = mem_data_ok && (pre > 0);
        exp_mreq = mreq;
        exp_perr = m_perr;
        if (acc) begin
            a.own = g;
            a.wr    = g ? data_wr : inst_wr;
            a.size  = g ? data_size : inst_size;
            a.wstrb = g ? data_wstrb : inst_wstrb;
            a.addr  = g ? data_addr : inst_addr;
            a.wdata = g ? data_wdata : inst_wdata;
            acc_q.push_back(a);
        end
        if (ret) ret_q.push_back('{own: m_q[0], rdata: mem_rdata});
        @(posedge clk);
        #1;
        if (ret) void'(m_q.pop_front());
        if (acc) m_q.push_back(g);
        if (acc) m_lockv = 1'b0;
        else if (mreq) begin
            m_lockv = 1'b1;
            m_lockown = g;
        end
        if (mem_data_ok && pre == 0) m_perr = 1'b1;
        if (acc && !g) inst_req = 1'b0;
        if (acc && g) data_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (m_q.size() == 0 && !inst_req && !data_req) break;
            mem_addr_ok = 1'b1;
            mem_data_ok = (m_q.size() > 0);
            mem_rdata   = $urandom;
            step();
        end
        mem_data_ok = 1'b0;
        mem_addr_ok = 1'b0;
    endtask

    initial begin
        chk_en = 1'b1;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Both request together: data first, then inst.
        new_inst();
        new_data();
        mem_addr_ok = 1'b1;
        step();
        step();
        mem_data_ok = 1'b1;
        mem_rdata = 32'h1111_2222;
        step();
        mem_rdata = 32'h3333_4444;
        step();
        mem_data_ok = 1'b0;

        // Stalled inst keeps the bus while data arrives.
        new_inst();
        mem_addr_ok = 1'b0;
        step();
        new_data();
        step();
        step();
        mem_addr_ok = 1'b1;
        step();
        step();
        drain();

        // Fill the owner FIFO with data reads, then free one slot.
        mem_addr_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!data_req) new_data();
            step();
        end
        mem_data_ok = 1'b1;
        mem_rdata = $urandom;
        step();
        mem_data_ok = 1'b0;
        step();
        drain();

        // Random traffic with random stalls and returns.
        for (int i = 0; i < 2000; i++) begin
            if (!inst_req && $urandom_range(0, 2) == 0) new_inst();
            if (!data_req && $urandom_range(0, 2) == 0) new_data();
            mem_addr_ok = ($urandom_range(0, 3) != 0);
            mem_data_ok = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
            mem_rdata   = $urandom;
            step();
        end
        drain();

        // Return with nothing outstanding.
        mem_data_ok = 1'b1;
        step();
        mem_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Reset mid-transaction with two outstanding and a lock.
        mem_addr_ok = 1'b1;
        new_data();
        step();
        new_inst();
        step();
        new_inst();
        mem_addr_ok = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        new_inst();
        mem_addr_ok = 1'b1;
        step();
        mem_data_ok = 1'b1;
        mem_rdata = 32'hcafe_f00d;
        step();
        mem_data_ok = 1'b0;
        step();
        step();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
